// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D cache memory arbiter: RAM status codes, arbiter FSM states
// and the data word returned to a requester whose access was aborted by a fault.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IACC  = 2'd1,
    DACC  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  localparam logic [31:0] ARB_FAULT_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the arbiter; master = caches plus RAM model, slave = arbiter.
// Waits are the only backpressure: a requester holds its request until its wait drops.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/arb_watchdog.sv
// Access watchdog: counts cycles of an access without ACCESS, trips at TIMEOUT-1 or on RAM ERROR.
// Trip is combinational in the tripping cycle; err is a sticky flag cleared only by reset.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic ack,
  input  logic ram_err,
  output logic trip,
  output logic err
);

  logic [7:0] tcnt_q, tcnt_d;
  logic       err_q, err_d;

  always_comb begin
    trip   = en && !ack && (ram_err || (tcnt_q == 8'(TIMEOUT - 1)));
    tcnt_d = tcnt_q;
    if (clr) begin
      tcnt_d = '0;
    end else if (en && !ack) begin
      tcnt_d = tcnt_q + 8'd1;
    end
    err_d = err_q | trip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to icache or dcache; RAM driven the cycle after a request, completion on ACCESS.
// Grant held until ACCESS, fault or requester drop; data wins unless D_STREAK data grants starved iREN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int D_STREAK = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t  state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic        fault_src_q, fault_src_d;  // 1: dcache faulted, 0: icache

  logic        d_req;
  logic        wd_clr, wd_en, wd_ack, wd_ram_err, wd_trip, wd_err;
  logic        i_done, d_done;
  logic        iwait, dwait, ram_ren, ram_wen;
  logic [31:0] iload, dload, ram_addr, ram_store;

  assign d_req      = bus.dREN | bus.dWEN;
  assign wd_clr     = (state_q == IDLE);
  assign wd_en      = !nRST && (((state_q == IACC) && bus.iREN) || ((state_q == DACC) && d_req));
  assign wd_ack     = (bus.ramstate == ACCESS);
  assign wd_ram_err = (bus.ramstate == ERROR);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (CLK),
    .rst     (nRST),
    .clr     (wd_clr),
    .en      (wd_en),
    .ack     (wd_ack),
    .ram_err (wd_ram_err),
    .trip    (wd_trip),
    .err     (wd_err)
  );

  always_comb begin
    state_d     = state_q;
    fault_src_d = fault_src_q;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(bus.iREN && (streak_q == 3'(D_STREAK)))) begin
          state_d = DACC;
        end else if (bus.iREN) begin
          state_d = IACC;
        end
      end
      IACC: begin
        ram_addr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          ram_ren = 1'b1;
          if (wd_ack) begin
            iwait   = 1'b0;
            iload   = bus.ramload;
            i_done  = 1'b1;
            state_d = IDLE;
          end else if (wd_trip) begin
            fault_src_d = 1'b0;
            state_d     = FAULT;
          end
        end
      end
      DACC: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ram_wen = bus.dWEN;
          ram_ren = !bus.dWEN;
          if (wd_ack) begin
            dwait   = 1'b0;
            dload   = bus.ramload;
            d_done  = 1'b1;
            state_d = IDLE;
          end else if (wd_trip) begin
            fault_src_d = 1'b1;
            state_d     = FAULT;
          end
        end
      end
      FAULT: begin
        if (fault_src_q) begin
          dwait = 1'b0;
          dload = ARB_FAULT_WORD;
        end else begin
          iwait = 1'b0;
          iload = ARB_FAULT_WORD;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any in-flight access in the same cycle it is seen.
    if (nRST) begin
      state_d   = IDLE;
      iwait     = 1'b1;
      dwait     = 1'b1;
      iload     = '0;
      dload     = '0;
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      i_done    = 1'b0;
      d_done    = 1'b0;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.iREN || i_done) begin
      streak_d = '0;
    end else if (d_done && (streak_q < 3'(D_STREAK))) begin
      streak_d = streak_q + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      fault_src_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      fault_src_q <= fault_src_d;
    end
  end

  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.err      = wd_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// fairness, watchdog timeout, ACCESS at the timeout limit and reset mid-access.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    ramstate_t   rs;
  } in_t;

  typedef struct packed {
    logic        iwait;
    logic        dwait;
    logic        ren;
    logic        wen;
    logic        err;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] iload;
    logic [31:0] dload;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(16), .D_STREAK(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic in_t in_v(input logic rst, input logic iren, input logic dren, input logic dwen,
                               input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                               input logic [31:0] rl, input ramstate_t rs);
    in_t r;
    r = '{rst, iren, dren, dwen, ia, da, ds, rl, rs};
    return r;
  endfunction

  function automatic out_t out_v(input logic iw, input logic dw, input logic ren, input logic wen,
                                 input logic e, input logic [31:0] addr, input logic [31:0] store,
                                 input logic [31:0] il, input logic [31:0] dl);
    out_t r;
    r = '{iw, dw, ren, wen, e, addr, store, il, dl};
    return r;
  endfunction

  function automatic out_t idle_o(input logic e);
    return out_v(1, 1, 0, 0, e, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={iw,dw,ren,wen,err,addr,store,iload,dload}=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input in_t i, input out_t e, input string nm);
    out_t a;
    nRST         = i.rst;
    bus.iREN     = i.iren;
    bus.dREN     = i.dren;
    bus.dWEN     = i.dwen;
    bus.iaddr    = i.iaddr;
    bus.daddr    = i.daddr;
    bus.dstore   = i.dstore;
    bus.ramload  = i.ramload;
    bus.ramstate = i.rs;
    @(negedge CLK);
    a = '{bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err,
          bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    chk(nm, a, e);
    @(posedge CLK);
    #1;
  endtask

  vec_t        vt [22];
  logic [31:0] rl;
  int          c;

  initial begin
    checks       = 0;
    failures     = 0;
    nRST         = 1'b1;
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
    @(posedge CLK);
    #1;

    vt[0]  = '{in_v(1,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[1]  = '{in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[2]  = '{in_v(0,1,0,0,32'h40,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[3]  = '{in_v(0,1,0,0,32'h40,32'h0,32'h0,32'h11112222,ACCESS),
               out_v(0,1,1,0,0,32'h40,32'h0,32'h11112222,32'h0)};
    vt[4]  = '{in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[5]  = '{in_v(0,1,0,1,32'h80,32'h100,32'hCAFEF00D,32'h0,FREE), idle_o(0)};
    vt[6]  = '{in_v(0,1,0,1,32'h80,32'h100,32'hCAFEF00D,32'h0,BUSY),
               out_v(1,1,0,1,0,32'h100,32'hCAFEF00D,32'h0,32'h0)};
    vt[7]  = '{in_v(0,1,0,1,32'h80,32'h100,32'hCAFEF00D,32'h5555AAAA,ACCESS),
               out_v(1,0,0,1,0,32'h100,32'hCAFEF00D,32'h0,32'h5555AAAA)};
    vt[8]  = '{in_v(0,1,0,0,32'h80,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[9]  = '{in_v(0,1,0,0,32'h80,32'h0,32'h0,32'h0BADF00D,ACCESS),
               out_v(0,1,1,0,0,32'h80,32'h0,32'h0BADF00D,32'h0)};
    vt[10] = '{in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[11] = '{in_v(0,0,1,0,32'h0,32'h200,32'h0,32'h0,FREE), idle_o(0)};
    vt[12] = '{in_v(0,0,1,0,32'h0,32'h200,32'h0,32'h12345678,ACCESS),
               out_v(1,0,1,0,0,32'h200,32'h0,32'h0,32'h12345678)};
    vt[13] = '{in_v(0,0,1,0,32'h0,32'h300,32'h0,32'h0,FREE), idle_o(0)};
    // Requester drops while granted: enables low, no completion despite ACCESS.
    vt[14] = '{in_v(0,0,0,0,32'h0,32'h300,32'h0,32'hDEADBEEF,ACCESS),
               out_v(1,1,0,0,0,32'h300,32'h0,32'h0,32'h0)};
    vt[15] = '{in_v(0,1,0,0,32'h44,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[16] = '{in_v(0,1,0,0,32'h44,32'h0,32'h0,32'h7,ACCESS),
               out_v(0,1,1,0,0,32'h44,32'h0,32'h7,32'h0)};
    vt[17] = '{in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0)};
    vt[18] = '{in_v(0,0,1,0,32'h0,32'h10,32'h0,32'h0,FREE), idle_o(0)};
    vt[19] = '{in_v(0,0,1,0,32'h0,32'h10,32'h0,32'h0,ERROR),
               out_v(1,1,1,0,0,32'h10,32'h0,32'h0,32'h0)};
    vt[20] = '{in_v(0,0,1,0,32'h0,32'h10,32'h0,32'h0,FREE),
               out_v(1,0,0,0,1,32'h0,32'h0,32'h0,32'hBAD1BAD1)};
    vt[21] = '{in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(1)};

    for (int k = 0; k < 22; k++) begin
      cyc(vt[k].i, vt[k].o, $sformatf("vec%0d", k));
    end

    // Reset in the middle of a data write.
    cyc(in_v(0,0,0,1,32'h0,32'h900,32'h1,32'h0,BUSY), idle_o(1), "rst_seq_idle");
    cyc(in_v(0,0,0,1,32'h0,32'h900,32'h1,32'h0,BUSY),
        out_v(1,1,0,1,1,32'h900,32'h1,32'h0,32'h0), "rst_seq_dacc");
    cyc(in_v(1,0,0,1,32'h0,32'h900,32'h1,32'h99,ACCESS), idle_o(1), "rst_seq_assert");
    cyc(in_v(0,0,0,1,32'h0,32'h900,32'h1,32'h99,ACCESS), idle_o(0), "rst_seq_after");
    cyc(in_v(0,0,0,1,32'h0,32'h900,32'h1,32'h99,ACCESS),
        out_v(1,0,0,1,0,32'h900,32'h1,32'h0,32'h99), "rst_seq_regrant");
    cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0), "rst_seq_end");

    // Both caches request continuously: four data grants, then one instruction grant.
    for (int n = 0; n < 20; n++) begin
      rl = 32'hA000 + 32'(n);
      c  = n / 2;
      if (n % 2 == 0) begin
        cyc(in_v(0,1,1,0,32'h600,32'h500,32'h0,rl,ACCESS), idle_o(0), "streak_idle");
      end else if (c % 5 == 4) begin
        cyc(in_v(0,1,1,0,32'h600,32'h500,32'h0,rl,ACCESS),
            out_v(0,1,1,0,0,32'h600,32'h0,rl,32'h0), "streak_icache");
      end else begin
        cyc(in_v(0,1,1,0,32'h600,32'h500,32'h0,rl,ACCESS),
            out_v(1,0,1,0,0,32'h500,32'h0,32'h0,rl), "streak_dcache");
      end
    end
    cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0), "streak_end");

    // ACCESS arrives in the same cycle the watchdog would trip: completion, no fault.
    cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'h0,BUSY), idle_o(0), "limit_idle");
    for (int n = 0; n < 15; n++) begin
      cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'h0,BUSY),
          out_v(1,1,1,0,0,32'h700,32'h0,32'h0,32'h0), "limit_busy");
    end
    cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'hFACE,ACCESS),
        out_v(1,0,1,0,0,32'h700,32'h0,32'h0,32'hFACE), "limit_access");
    cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0), "limit_no_err");
    cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0), "limit_no_err2");

    // RAM stuck BUSY: fault 16 cycles after the grant, sticky err until reset.
    cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'h0,BUSY), idle_o(0), "tmo_idle");
    for (int n = 0; n < 16; n++) begin
      cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'h0,BUSY),
          out_v(1,1,1,0,0,32'h700,32'h0,32'h0,32'h0), "tmo_busy");
    end
    cyc(in_v(0,0,1,0,32'h0,32'h700,32'h0,32'h0,BUSY),
        out_v(1,0,0,0,1,32'h0,32'h0,32'h0,32'hBAD1BAD1), "tmo_fault");
    for (int n = 0; n < 3; n++) begin
      cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(1), "tmo_err_sticky");
    end
    cyc(in_v(1,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(1), "tmo_rst");
    cyc(in_v(0,0,0,0,32'h0,32'h0,32'h0,32'h0,FREE), idle_o(0), "tmo_err_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and data cache of one core. It sits below `icache`/`dcache` and above the RAM model. It grants the shared RAM port to one requester at a time, holds the grant until the RAM reports `ACCESS`, and returns data and wait status to the requester. It also applies bounded fairness, so the icache is not starved by back-to-back data traffic, and a watchdog that recovers from a hung RAM.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles in an access state without `ACCESS` before error recovery; legal range 2..255.
- `D_STREAK`, 4: maximum consecutive data grants while `iREN` is pending; legal range 1..7.

Ports:
- Reset polarity: one clock; reset is synchronous and active-high. The reset port keeps the codebase name `nRST`, but reset is asserted when `nRST`=1, sampled on `posedge CLK`.
- `CLK`  in  1  system clock
- `nRST`  in  1  synchronous active-high reset
- `iREN`  in  1  icache read request
- `iaddr`  in  32  icache word address
- `dREN`  in  1  dcache read request
- `dWEN`  in  1  dcache write request; `dWEN` wins if both `dWEN` and `dREN` are set
- `daddr`  in  32  dcache address
- `dstore`  in  32  dcache write data
- `iwait`  out  1  high unless the icache access completes this cycle
- `dwait`  out  1  high unless the dcache access completes this cycle
- `iload`  out  32  instruction data, valid when `iwait`=0
- `dload`  out  32  read data, valid when `dwait`=0
- `ramREN`, `ramWEN`  out  1 each  RAM enables
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  `FREE`=0, `BUSY`=1, `ACCESS`=2, `ERROR`=3
- `err`  out  1  sticky; set on timeout or `ERROR`, cleared only by reset

## Operation
- States: `IDLE`, `IACC`, `DACC`, `FAULT`.
- `IDLE`:
  - RAM enables are low and both waits are high.
  - Priority: data request (`dREN|dWEN`) over `iREN`, except when `streak`=`D_STREAK` and `iREN` is set; then the icache wins.
  - The winner's state is entered the next cycle.
- `IACC`/`DACC`:
  - `ramaddr`, enables and `ramstore` are driven combinationally from the live inputs of the granted requester.
  - On `ramstate`=`ACCESS`, the granted wait is driven low combinationally and the load equals `ramload`. Next state is `IDLE`.
- Fairness counter `streak` (3 bits):
  - Increments on each `DACC` completion while `iREN` is high, saturating at `D_STREAK`.
  - Clears on an `IACC` completion, or on any cycle with `iREN` low.
- Watchdog `tcnt` (8 bits):
  - Clears on entry to an access state and increments each cycle in that state without `ACCESS`.
  - Trips when `tcnt`=`TIMEOUT`-1 with no `ACCESS`, or when `ramstate`=`ERROR`. Either event moves the FSM to `FAULT` next cycle and sets `err`.
- `FAULT` (one cycle):
  - Enables are low.
  - The faulted requester's wait is low, with load = 32'hBAD1BAD1.
  - Next state is `IDLE`.
- Requester drop: if the granted request deasserts before completion, enables go low the same cycle (combinational), the next state is `IDLE`, and no completion is reported.
- The wait of a non-granted requester is always high.

## Timing
- Reset values:
  - State `IDLE`, `streak`=0, `tcnt`=0, `err`=0.
  - `iwait`=`dwait`=1, `ramREN`=`ramWEN`=0.
  - `ramaddr`, `ramstore`, `iload`, `dload` are all 0.
- Minimum latency: request at cycle N, RAM driven at N+1, completion at N+1 if `ramstate`=`ACCESS` then. Back-to-back accesses are spaced at least 2 cycles apart (one `IDLE` cycle between them).
- Requesters hold address, data and enable until their wait is low.
- Reset asserted in any state forces `IDLE` next edge and drops enables that cycle; an in-flight access is abandoned.
- Simultaneous `ACCESS` and `tcnt` limit in the same cycle: `ACCESS` wins, and no fault is raised.

## Structure
- Add to `cpu_types_pkg`:
  - `ramstate_t` enum.
  - `arb_state_t` enum.
  - Constant `ARB_FAULT_WORD` = 32'hBAD1BAD1.
- One sub-module, `arb_watchdog`, containing `tcnt`, the trip compare and the `err` flag, with inputs clear/enable/ack.
- The top level holds the FSM, priority/fairness logic and the output mux. It is instantiated in place of the direct cache-to-RAM wiring inside `memory_control`.

## Test plan
- Lone `iREN`, `iaddr`=0x40, RAM `ACCESS` at the first access cycle -> `ramREN`=1 with `ramaddr`=0x40 at N+1, and `iwait`=0 with `iload`=`ramload` in that same cycle.
- `iREN` and `dWEN` together, `daddr`=0x100, `dstore`=0xCAFEF00D -> data is granted first (`ramWEN`=1, `ramstore`=0xCAFEF00D); the icache is served after the data access completes.
- `dREN` and `iREN` held continuously with `D_STREAK`=4 -> 4 data completions, then 1 instruction completion, repeating; `streak` never exceeds 4.
- RAM stuck at `BUSY` with `TIMEOUT`=16 -> `FAULT` entered 16 cycles after grant, `dload`=0xBAD1BAD1 with `dwait`=0 for 1 cycle, `err`=1 until reset.
- `nRST`=1 mid-`DACC` -> next cycle `IDLE`, enables 0, `err` 0, and no completion reported.
